// File: rtl/irq_controller.sv
// Interrupt controller: synchronised edge capture, per-source masking, fixed
// priority selection and a single-level INT_ACK/RETI handshake with the core.
module irq_controller #(
    parameter int         NUM_IRQ  = 4,
    parameter logic [6:0] VEC_BASE = 7'h70
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic               MASK_WE,
    input  logic [NUM_IRQ-1:0] MASK_DATA,
    input  logic               GIE_SET,
    input  logic               GIE_CLR,
    input  logic               INT_ACK,
    input  logic               RETI,
    output logic               IF,
    output logic [6:0]         VECTOR,
    output logic [NUM_IRQ-1:0] PENDING,
    output logic               IN_SERVICE
);
    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE
    } state_t;

    state_t state, state_d;

    logic [NUM_IRQ-1:0] sync1, sync2, sync2_d;
    logic [NUM_IRQ-1:0] rise, mask, mask_d, eligible, clr, pending_d;
    logic [IDX_W-1:0]   sel, req_idx, req_idx_d;
    logic               any_eligible, gie, gie_d, if_d, in_service_d;
    logic [6:0]         vector_d;

    assign rise         = sync2 & ~sync2_d;
    assign mask_d       = MASK_WE ? MASK_DATA : mask;
    assign eligible     = PENDING & ~mask;
    assign any_eligible = |eligible;
    assign pending_d    = (PENDING & ~clr) | rise;

    // Descending scan so the lowest eligible index is the one left standing.
    always_comb begin
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) sel = IDX_W'(i);
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state;
        if_d         = IF;
        vector_d     = VECTOR;
        in_service_d = IN_SERVICE;
        req_idx_d    = req_idx;
        clr          = '0;
        gie_d        = GIE_CLR ? 1'b0 : (GIE_SET ? 1'b1 : gie);

        case (state)
            ST_IDLE: begin
                if (gie && any_eligible) begin
                    if_d      = 1'b1;
                    vector_d  = VEC_BASE + 7'(sel);
                    req_idx_d = sel;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (INT_ACK) begin
                    clr[req_idx] = 1'b1;
                    gie_d        = 1'b0;
                    if_d         = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = ST_SERVICE;
                end else if (!gie_d || mask_d[req_idx]) begin
                    // Withdraw on the same edge that disables or masks the source.
                    if_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (RETI) begin
                    gie_d        = 1'b1;
                    in_service_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments for all registered state, so every flop
    // samples the values from before this edge regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            sync1      <= '0;
            sync2      <= '0;
            sync2_d    <= '0;
            mask       <= '1;
            gie        <= 1'b0;
            req_idx    <= '0;
            IF         <= 1'b0;
            VECTOR     <= 7'h00;
            PENDING    <= '0;
            IN_SERVICE <= 1'b0;
        end else begin
            state      <= state_d;
            sync1      <= IRQ;
            sync2      <= sync1;
            sync2_d    <= sync2;
            mask       <= mask_d;
            gie        <= gie_d;
            req_idx    <= req_idx_d;
            IF         <= if_d;
            VECTOR     <= vector_d;
            PENDING    <= pending_d;
            IN_SERVICE <= in_service_d;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: expected outputs are queued as each step
// is driven and compared against the DUT after the step's clock edges.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] irq = '0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_data = '0;
    logic       gie_set = 1'b0;
    logic       gie_clr = 1'b0;
    logic       int_ack = 1'b0;
    logic       reti = 1'b0;
    logic       if_flag;
    logic [6:0] vector;
    logic [3:0] pending;
    logic       in_service;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        logic       if_v;
        logic [6:0] vec;
        logic [3:0] pend;
        logic       ins;
    } exp_t;

    exp_t sb_q[$];

    irq_controller #(.NUM_IRQ(4), .VEC_BASE(7'h70)) dut (
        .CLK       (clk),
        .RST       (rst),
        .IRQ       (irq),
        .MASK_WE   (mask_we),
        .MASK_DATA (mask_data),
        .GIE_SET   (gie_set),
        .GIE_CLR   (gie_clr),
        .INT_ACK   (int_ack),
        .RETI      (reti),
        .IF        (if_flag),
        .VECTOR    (vector),
        .PENDING   (pending),
        .IN_SERVICE(in_service)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; outputs are then sampled 1 time unit later.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, ".IF"},         16'(if_flag),    16'(e.if_v));
            check({e.tag, ".VECTOR"},     16'(vector),     16'(e.vec));
            check({e.tag, ".PENDING"},    16'(pending),    16'(e.pend));
            check({e.tag, ".IN_SERVICE"}, 16'(in_service), 16'(e.ins));
        end
    endtask

    // Queue the expected outputs, run n edges, then compare.
    task automatic cyc(input int n, input string tag, input logic i, input logic [6:0] v,
                       input logic [3:0] p, input logic s);
        exp_t e;
        e.tag  = tag;
        e.if_v = i;
        e.vec  = v;
        e.pend = p;
        e.ins  = s;
        sb_q.push_back(e);
        step(n);
        drain();
    endtask

    initial begin
        // Reset with all lines high, then capture without GIE.
        rst = 1'b1;
        irq = 4'hF;
        cyc(2, "reset", 1'b0, 7'h00, 4'h0, 1'b0);
        rst = 1'b0;
        cyc(2, "rst_sync", 1'b0, 7'h00, 4'h0, 1'b0);
        cyc(1, "rst_pend", 1'b0, 7'h00, 4'hF, 1'b0);
        cyc(3, "no_gie", 1'b0, 7'h00, 4'hF, 1'b0);

        irq = 4'h0;
        rst = 1'b1;
        cyc(1, "reset2", 1'b0, 7'h00, 4'h0, 1'b0);
        rst = 1'b0;

        // Basic entry/exit on source 2.
        mask_we   = 1'b1;
        mask_data = 4'h0;
        gie_set   = 1'b1;
        step(1);
        mask_we = 1'b0;
        gie_set = 1'b0;
        irq = 4'b0100;
        cyc(3, "basic_pend", 1'b0, 7'h00, 4'h4, 1'b0);
        cyc(1, "basic_if", 1'b1, 7'h72, 4'h4, 1'b0);
        irq = 4'h0;
        cyc(2, "basic_hold", 1'b1, 7'h72, 4'h4, 1'b0);
        int_ack = 1'b1;
        cyc(1, "basic_ack", 1'b0, 7'h72, 4'h0, 1'b1);
        cyc(1, "spur_ack", 1'b0, 7'h72, 4'h0, 1'b1);
        int_ack = 1'b0;
        reti = 1'b1;
        cyc(1, "basic_reti", 1'b0, 7'h72, 4'h0, 1'b0);
        cyc(1, "spur_reti", 1'b0, 7'h72, 4'h0, 1'b0);
        reti = 1'b0;

        // Priority and queueing: sources 3 and 1 together.
        irq = 4'b1010;
        cyc(3, "prio_pend", 1'b0, 7'h72, 4'hA, 1'b0);
        cyc(1, "prio_if", 1'b1, 7'h71, 4'hA, 1'b0);
        irq = 4'h0;
        int_ack = 1'b1;
        cyc(1, "prio_ack", 1'b0, 7'h71, 4'h8, 1'b1);
        int_ack = 1'b0;
        reti = 1'b1;
        cyc(1, "prio_reti", 1'b0, 7'h71, 4'h8, 1'b0);
        reti = 1'b0;
        cyc(1, "queue_if", 1'b1, 7'h73, 4'h8, 1'b0);
        int_ack = 1'b1;
        cyc(1, "queue_ack", 1'b0, 7'h73, 4'h0, 1'b1);
        int_ack = 1'b0;

        // No nesting: source 0 arrives during service.
        irq = 4'b0001;
        cyc(3, "nest_pend", 1'b0, 7'h73, 4'h1, 1'b1);
        irq = 4'h0;
        cyc(2, "nest_hold", 1'b0, 7'h73, 4'h1, 1'b1);
        reti = 1'b1;
        cyc(1, "nest_reti", 1'b0, 7'h73, 4'h1, 1'b0);
        reti = 1'b0;
        cyc(1, "nest_if", 1'b1, 7'h70, 4'h1, 1'b0);
        int_ack = 1'b1;
        cyc(1, "nest_ack", 1'b0, 7'h70, 4'h0, 1'b1);
        int_ack = 1'b0;
        reti = 1'b1;
        cyc(1, "nest_done", 1'b0, 7'h70, 4'h0, 1'b0);
        reti = 1'b0;

        // Withdrawal by masking the requesting source, then re-raise.
        irq = 4'b0010;
        cyc(4, "wd_if", 1'b1, 7'h71, 4'h2, 1'b0);
        irq = 4'h0;
        mask_we   = 1'b1;
        mask_data = 4'b0010;
        cyc(1, "wd_mask", 1'b0, 7'h71, 4'h2, 1'b0);
        mask_we = 1'b0;
        cyc(2, "wd_hold", 1'b0, 7'h71, 4'h2, 1'b0);
        mask_we   = 1'b1;
        mask_data = 4'h0;
        cyc(1, "wd_unmask", 1'b0, 7'h71, 4'h2, 1'b0);
        mask_we = 1'b0;
        cyc(1, "wd_reraise", 1'b1, 7'h71, 4'h2, 1'b0);
        int_ack = 1'b1;
        cyc(1, "wd_ack", 1'b0, 7'h71, 4'h0, 1'b1);
        int_ack = 1'b0;
        reti = 1'b1;
        cyc(1, "wd_reti", 1'b0, 7'h71, 4'h0, 1'b0);
        reti = 1'b0;

        // Set/clear collision: second edge on source 2 lands with its ACK.
        irq = 4'b0100;
        step(1);
        irq = 4'h0;
        cyc(2, "col_pend", 1'b0, 7'h71, 4'h4, 1'b0);
        irq = 4'b0100;
        cyc(1, "col_if", 1'b1, 7'h72, 4'h4, 1'b0);
        step(1);
        int_ack = 1'b1;
        cyc(1, "col_ack", 1'b0, 7'h72, 4'h4, 1'b1);
        int_ack = 1'b0;
        irq = 4'h0;
        reti = 1'b1;
        cyc(1, "col_reti", 1'b0, 7'h72, 4'h4, 1'b0);
        reti = 1'b0;
        cyc(1, "col_reraise", 1'b1, 7'h72, 4'h4, 1'b0);

        // Withdrawal by GIE_CLR, spurious ACK in IDLE, then GIE_SET re-raises.
        gie_clr = 1'b1;
        cyc(1, "gclr_wd", 1'b0, 7'h72, 4'h4, 1'b0);
        gie_clr = 1'b0;
        cyc(2, "gclr_hold", 1'b0, 7'h72, 4'h4, 1'b0);
        int_ack = 1'b1;
        cyc(1, "idle_ack", 1'b0, 7'h72, 4'h4, 1'b0);
        int_ack = 1'b0;
        gie_set = 1'b1;
        cyc(1, "gset", 1'b0, 7'h72, 4'h4, 1'b0);
        gie_set = 1'b0;
        cyc(1, "gset_if", 1'b1, 7'h72, 4'h4, 1'b0);
        int_ack = 1'b1;
        cyc(1, "gset_ack", 1'b0, 7'h72, 4'h0, 1'b1);
        int_ack = 1'b0;

        // Reset mid-service aborts without RETI.
        rst = 1'b1;
        cyc(1, "rst_service", 1'b0, 7'h00, 4'h0, 1'b0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
